// File: rtl/fe_fetch_unit_pkg.sv
// Shared widths, reset constants and FSM encodings for the fetch stage.
package fe_fetch_unit_pkg;

    localparam int unsigned FE_DBITS        = 32;
    localparam int unsigned FE_INSTBITS     = 32;
    localparam int unsigned FE_CANARY_WIDTH = 4;

    localparam int unsigned FE_latch_WIDTH        = FE_INSTBITS + 3 * FE_DBITS + FE_CANARY_WIDTH;
    localparam int unsigned from_DE_to_FE_WIDTH   = 1;
    localparam int unsigned from_AGEX_to_FE_WIDTH = 1 + FE_DBITS;

    localparam logic [31:0] FE_STARTPC      = 32'h200;
    localparam logic [3:0]  FE_CANARY_VALUE = 4'hC;

    typedef enum logic [1:0] {
        FE_FETCH = 2'd0,
        FE_WAIT  = 2'd1,
        FE_HOLD  = 2'd2
    } fe_state_e;

endpackage

// File: rtl/fe_hold_buf.sv
// Single-entry skid register holding a fetched word while DE is stalled.
module fe_hold_buf
    import fe_fetch_unit_pkg::*;
#(
    parameter int unsigned DBITS    = FE_DBITS,
    parameter int unsigned INSTBITS = FE_INSTBITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                capture,
    input  logic                release_entry,
    input  logic                flush,
    input  logic [INSTBITS-1:0] cap_inst,
    input  logic [DBITS-1:0]    cap_pc,
    output logic                valid,
    output logic [INSTBITS-1:0] inst,
    output logic [DBITS-1:0]    pc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            inst  <= cap_inst;
            pc    <= cap_pc;
        end else if (release_entry) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fe_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem request in flight and drives the FE latch for DE.
module fe_fetch_unit
    import fe_fetch_unit_pkg::*;
#(
    parameter int unsigned             DBITS        = FE_DBITS,
    parameter int unsigned             INSTBITS     = FE_INSTBITS,
    parameter logic [DBITS-1:0]        STARTPC      = DBITS'(FE_STARTPC),
    parameter int unsigned             CANARY_WIDTH = FE_CANARY_WIDTH,
    parameter logic [CANARY_WIDTH-1:0] CANARY_VALUE = CANARY_WIDTH'(FE_CANARY_VALUE)
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         from_DE_to_FE,
    input  logic                                         br_redirect_AGEX,
    input  logic [DBITS-1:0]                             br_target_AGEX,
    output logic                                         imem_req_valid,
    output logic [DBITS-1:0]                             imem_req_addr,
    input  logic                                         imem_req_ready,
    input  logic                                         imem_rsp_valid,
    input  logic [INSTBITS-1:0]                          imem_rsp_data,
    output logic [INSTBITS+3*DBITS+CANARY_WIDTH-1:0]     FE_latch_out
);

    localparam int unsigned LatchWidth = INSTBITS + 3 * DBITS + CANARY_WIDTH;

    fe_state_e             state_q;
    logic [DBITS-1:0]      pc_q;
    logic [DBITS-1:0]      req_pc_q;
    logic [DBITS-1:0]      inst_count_q;
    logic                  squash_q;
    logic [LatchWidth-1:0] latch_q;

    logic                  hb_valid;
    logic [INSTBITS-1:0]   hb_inst;
    logic [DBITS-1:0]      hb_pc;

    logic                  rsp_live;
    logic                  deliver_rsp;
    logic                  deliver_hold;
    logic                  hb_capture;
    logic [DBITS-1:0]      next_pc;
    logic [INSTBITS-1:0]   deliver_inst;
    logic [DBITS-1:0]      deliver_pc;
    logic [LatchWidth-1:0] deliver_word;

    assign next_pc = req_pc_q + DBITS'(4);

    // A response is usable only if it was not squashed and no redirect is landing this cycle.
    assign rsp_live     = (state_q == FE_WAIT) && imem_rsp_valid && !squash_q && !br_redirect_AGEX;
    assign deliver_rsp  = rsp_live && !from_DE_to_FE;
    assign hb_capture   = rsp_live && from_DE_to_FE;
    assign deliver_hold = (state_q == FE_HOLD) && hb_valid && !from_DE_to_FE && !br_redirect_AGEX;

    assign deliver_inst = deliver_hold ? hb_inst : imem_rsp_data;
    assign deliver_pc   = deliver_hold ? hb_pc   : req_pc_q;
    assign deliver_word = {deliver_inst, deliver_pc, deliver_pc + DBITS'(4),
                           inst_count_q + DBITS'(1), CANARY_VALUE};

    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = pc_q;
        case (state_q)
            FE_FETCH: imem_req_valid = !br_redirect_AGEX;
            FE_WAIT: begin
                // Back-to-back issue of the sequential successor alongside delivery.
                imem_req_valid = deliver_rsp;
                imem_req_addr  = next_pc;
            end
            default: imem_req_valid = 1'b0;
        endcase
        if (!reset_n) begin
            imem_req_valid = 1'b0;
        end
    end

    fe_hold_buf #(
        .DBITS    (DBITS),
        .INSTBITS (INSTBITS)
    ) u_hold_buf (
        .clk           (clk),
        .reset_n       (reset_n),
        .capture       (hb_capture),
        .release_entry (deliver_hold),
        .flush         (br_redirect_AGEX),
        .cap_inst      (imem_rsp_data),
        .cap_pc        (req_pc_q),
        .valid         (hb_valid),
        .inst          (hb_inst),
        .pc            (hb_pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FE_FETCH;
            pc_q         <= STARTPC;
            req_pc_q     <= STARTPC;
            inst_count_q <= '0;
            squash_q     <= 1'b0;
            latch_q      <= '0;
        end else if (br_redirect_AGEX) begin
            pc_q    <= br_target_AGEX;
            latch_q <= '0;
            if ((state_q == FE_WAIT) && !imem_rsp_valid) begin
                squash_q <= 1'b1;
                state_q  <= FE_WAIT;
            end else begin
                squash_q <= 1'b0;
                state_q  <= FE_FETCH;
            end
        end else begin
            if (deliver_rsp || deliver_hold) begin
                latch_q      <= deliver_word;
                inst_count_q <= inst_count_q + DBITS'(1);
            end else if (!from_DE_to_FE) begin
                latch_q <= '0;
            end

            case (state_q)
                FE_FETCH: begin
                    if (imem_req_valid && imem_req_ready) begin
                        req_pc_q <= pc_q;
                        state_q  <= FE_WAIT;
                    end
                end
                FE_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (squash_q) begin
                            squash_q <= 1'b0;
                            state_q  <= FE_FETCH;
                        end else begin
                            pc_q <= next_pc;
                            if (from_DE_to_FE) begin
                                state_q <= FE_HOLD;
                            end else if (imem_req_ready) begin
                                req_pc_q <= next_pc;
                            end else begin
                                state_q <= FE_FETCH;
                            end
                        end
                    end
                end
                FE_HOLD: begin
                    if (!from_DE_to_FE) begin
                        state_q <= FE_FETCH;
                    end
                end
                default: state_q <= FE_FETCH;
            endcase
        end
    end

    assign FE_latch_out = latch_q;

endmodule

// File: tb/tb_fe_fetch_unit.sv
// Directed bench for fe_fetch_unit with a small latency-programmable instruction memory model.
module tb_fe_fetch_unit;

    logic         clk;
    logic         reset_n;
    logic         from_DE_to_FE;
    logic         br_redirect_AGEX;
    logic [31:0]  br_target_AGEX;
    logic         imem_req_valid;
    logic [31:0]  imem_req_addr;
    logic         imem_req_ready;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic [131:0] FE_latch_out;

    int          n_vec = 0;
    int          n_bad = 0;
    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;
    int          lat;

    fe_fetch_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .from_DE_to_FE    (from_DE_to_FE),
        .br_redirect_AGEX (br_redirect_AGEX),
        .br_target_AGEX   (br_target_AGEX),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .FE_latch_out     (FE_latch_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0013};
    endfunction

    function automatic logic [131:0] lw(input logic [31:0] inst, input logic [31:0] pc,
                                        input logic [31:0] pcplus, input logic [31:0] count);
        return {inst, pc, pcplus, count, 4'hC};
    endfunction

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Called mid-cycle: samples the handshake, crosses the edge, then advances the memory.
    task automatic step();
        logic        acc;
        logic        rsp_before;
        logic [31:0] a;
        acc        = imem_req_valid && imem_req_ready;
        rsp_before = imem_rsp_valid;
        a          = imem_req_addr;
        chk("one_outstanding", {131'd0, acc && pend && !rsp_before}, 132'd0);
        @(posedge clk);
        #1;
        if (rsp_before) pend = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = a;
            cnt       = lat;
        end
        if (pend && cnt > 0) cnt--;
        imem_rsp_valid = pend && (cnt == 0);
        imem_rsp_data  = imem_rsp_valid ? mem_word(pend_addr) : 32'd0;
    endtask

    task automatic cycle();
        mid();
        step();
    endtask

    initial begin
        reset_n          = 1'b0;
        from_DE_to_FE    = 1'b0;
        br_redirect_AGEX = 1'b0;
        br_target_AGEX   = 32'd0;
        imem_req_ready   = 1'b1;
        imem_rsp_valid   = 1'b0;
        imem_rsp_data    = 32'd0;
        pend             = 1'b0;
        pend_addr        = 32'd0;
        cnt              = 0;
        lat              = 1;

        mid();
        chk("rst_latch", FE_latch_out, 132'd0);
        chk("rst_req_valid", {131'd0, imem_req_valid}, 132'd0);
        step();
        cycle();
        reset_n = 1'b1;

        // 1-cycle memory, no stalls
        mid();
        chk("first_req_valid", {131'd0, imem_req_valid}, 132'd1);
        chk("first_req_addr", {100'd0, imem_req_addr}, {100'd0, 32'h200});
        step();
        chk("bubble_before_first", FE_latch_out, 132'd0);
        mid();
        chk("req_addr_204", {100'd0, imem_req_addr}, {100'd0, 32'h204});
        step();
        chk("latch_200", FE_latch_out, lw(32'h0200_0013, 32'h200, 32'h204, 32'd1));
        mid();
        chk("req_addr_208", {100'd0, imem_req_addr}, {100'd0, 32'h208});
        step();
        chk("latch_204", FE_latch_out, lw(32'h0204_0013, 32'h204, 32'h208, 32'd2));

        // DE stall for three cycles: 0x208 goes to the hold buffer
        from_DE_to_FE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("stall_no_req", {131'd0, imem_req_valid}, 132'd0);
            step();
            chk("stall_latch_holds", FE_latch_out, lw(32'h0204_0013, 32'h204, 32'h208, 32'd2));
        end
        from_DE_to_FE = 1'b0;
        mid();
        chk("hold_release_no_req", {131'd0, imem_req_valid}, 132'd0);
        step();
        chk("latch_208_from_hold", FE_latch_out, lw(32'h0208_0013, 32'h208, 32'h20C, 32'd3));
        mid();
        chk("req_after_hold", {100'd0, imem_req_valid, imem_req_addr}, {100'd1, 32'h20C});
        step();
        chk("bubble_after_hold", FE_latch_out, 132'd0);

        // Redirect while 0x210 is outstanding on a 2-cycle memory
        lat = 2;
        mid();
        chk("req_addr_210", {100'd0, imem_req_addr}, {100'd0, 32'h210});
        step();
        chk("latch_20c", FE_latch_out, lw(32'h020C_0013, 32'h20C, 32'h210, 32'd4));
        br_redirect_AGEX = 1'b1;
        br_target_AGEX   = 32'h400;
        mid();
        chk("redirect_no_req", {131'd0, imem_req_valid}, 132'd0);
        step();
        chk("redirect_latch_zero", FE_latch_out, 132'd0);
        br_redirect_AGEX = 1'b0;
        mid();
        chk("squash_no_req", {131'd0, imem_req_valid}, 132'd0);
        step();
        chk("late_rsp_discarded", FE_latch_out, 132'd0);
        lat = 1;
        mid();
        chk("req_at_target", {100'd0, imem_req_valid, imem_req_addr}, {100'd1, 32'h400});
        step();
        chk("bubble_after_target", FE_latch_out, 132'd0);
        mid();
        step();
        chk("latch_400", FE_latch_out, lw(32'h0400_0013, 32'h400, 32'h404, 32'd5));

        // Redirect on top of a stall with the hold buffer full
        from_DE_to_FE = 1'b1;
        cycle();
        chk("hold_404_latch_holds", FE_latch_out, lw(32'h0400_0013, 32'h400, 32'h404, 32'd5));
        br_redirect_AGEX = 1'b1;
        br_target_AGEX   = 32'h480;
        mid();
        chk("redirect_hold_no_req", {131'd0, imem_req_valid}, 132'd0);
        step();
        chk("redirect_over_stall", FE_latch_out, 132'd0);
        br_redirect_AGEX = 1'b0;
        from_DE_to_FE    = 1'b0;
        mid();
        chk("req_at_480", {100'd0, imem_req_valid, imem_req_addr}, {100'd1, 32'h480});
        step();
        mid();
        chk("req_addr_484", {100'd0, imem_req_addr}, {100'd0, 32'h484});
        step();
        chk("latch_480_buffer_dropped", FE_latch_out,
            lw(32'h0480_0013, 32'h480, 32'h484, 32'd6));

        // Memory not ready for four cycles
        imem_req_ready = 1'b0;
        mid();
        chk("notready_addr_0", {100'd0, imem_req_valid, imem_req_addr}, {100'd1, 32'h488});
        step();
        chk("latch_484", FE_latch_out, lw(32'h0484_0013, 32'h484, 32'h488, 32'd7));
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("notready_addr_stable", {100'd0, imem_req_valid, imem_req_addr},
                {100'd1, 32'h488});
            step();
            chk("notready_bubble", FE_latch_out, 132'd0);
        end
        imem_req_ready = 1'b1;
        mid();
        chk("ready_addr_488", {100'd0, imem_req_valid, imem_req_addr}, {100'd1, 32'h488});
        step();
        lat = 3;
        mid();
        step();
        chk("latch_488", FE_latch_out, lw(32'h0488_0013, 32'h488, 32'h48C, 32'd8));
        mid();
        chk("wait_no_req", {131'd0, imem_req_valid}, 132'd0);
        step();

        // Asynchronous reset with 0x48C still in flight
        reset_n        = 1'b0;
        pend           = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        #1;
        chk("async_rst_latch", FE_latch_out, 132'd0);
        chk("async_rst_req_valid", {131'd0, imem_req_valid}, 132'd0);
        cycle();
        cycle();
        reset_n = 1'b1;
        lat     = 1;
        mid();
        chk("post_rst_req", {100'd0, imem_req_valid, imem_req_addr}, {100'd1, 32'h200});
        step();
        chk("post_rst_bubble", FE_latch_out, 132'd0);
        mid();
        step();
        chk("post_rst_latch_200", FE_latch_out, lw(32'h0200_0013, 32'h200, 32'h204, 32'd1));

        // Redirect coinciding with a response, then PC wrap at the top of memory
        br_redirect_AGEX = 1'b1;
        br_target_AGEX   = 32'hFFFF_FFFC;
        cycle();
        chk("redirect_with_rsp_latch", FE_latch_out, 132'd0);
        br_redirect_AGEX = 1'b0;
        mid();
        chk("req_at_top", {100'd0, imem_req_valid, imem_req_addr}, {100'd1, 32'hFFFF_FFFC});
        step();
        mid();
        chk("req_addr_wrapped", {100'd0, imem_req_valid, imem_req_addr}, {100'd1, 32'h0});
        step();
        chk("latch_pcplus_wrap", FE_latch_out,
            lw(32'hFFFC_0013, 32'hFFFF_FFFC, 32'h0000_0000, 32'd2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fe_fetch_unit.md
Name: fe_fetch_unit

Overview:
- Fetch stage of the in-order RISC-V pipeline.
- Owns the PC and issues single-outstanding requests to instruction memory over a valid/ready request and valid response interface.
- Produces the FE latch that DE consumes: {inst, PC, pcplus, inst_count, bus_canary}.
- Consumes the DE stall bit (from_DE_to_FE) and the AGEX branch redirect; converts them into latch hold, bubble insertion and in-flight squash.

Parameters:
- DBITS, 32, data/address width
- INSTBITS, 32, instruction width
- STARTPC, 32'h200, PC after reset
- CANARY_WIDTH, 4, bus canary field width
- CANARY_VALUE, 4'hC, constant canary appended to every latch word

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- from_DE_to_FE  in  1  DE stall; 1 = DE did not consume the FE latch this cycle
- br_redirect_AGEX  in  1  taken branch/jump resolved in AGEX
- br_target_AGEX  in  DBITS  redirect PC
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  DBITS  fetch address, word-aligned
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid, never earlier than the cycle after acceptance
- imem_rsp_data  in  INSTBITS  fetched instruction
- FE_latch_out  out  FE_latch_WIDTH  {inst, PC, pcplus, inst_count, bus_canary}; MSB first

Behaviour:
- Reset (reset_n=0, asynchronous):
  - PC=STARTPC; inst_count=0; state=FETCH; squash=0; hold buffer invalid.
  - FE_latch_out=0; imem_req_valid=0.
- States:
  - FETCH: imem_req_valid=!br_redirect_AGEX; addr=PC. On valid&ready: req_pc<=PC; go to WAIT.
  - WAIT: one request outstanding.
  - HOLD: response captured in the hold buffer while DE is stalled.
- WAIT with rsp_valid:
  - squash=1: discard the response; squash<=0; go to FETCH.
  - stall=0: deliver. Latch <= {rsp_data, req_pc, req_pc+4, inst_count+1, CANARY_VALUE}; inst_count++; PC<=req_pc+4.
    - Same cycle, also assert imem_req_valid with addr=req_pc+4.
    - If ready: req_pc<=req_pc+4, stay in WAIT. Otherwise go to FETCH.
    - Throughput: 1 inst/cycle with 1-cycle memory.
  - stall=1: buffer the response; PC<=req_pc+4; go to HOLD.
- HOLD: when stall=0, deliver the buffered word to the latch (inst_count++), invalidate the buffer, go to FETCH. No request is issued in HOLD.
- Latch update rule when no redirect:
  - stall=1: latch holds its value.
  - stall=0 and nothing delivered: latch <= 0, an all-zero bubble (DE treats inst==0 as a bubble).
- Redirect (highest priority, overrides stall):
  - PC<=br_target_AGEX; latch<=0; hold buffer invalidated; inst_count unchanged.
  - If in WAIT with the response not arriving this cycle: squash<=1, stay in WAIT. Otherwise go to FETCH.
  - A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle. A request offered earlier but not accepted is withdrawn; valid may drop without acceptance, on redirect only.
- Request stability: while imem_req_valid=1 and ready=0 with no redirect, addr stays stable.
- Arithmetic: pcplus=PC+4 modulo 2^DBITS; inst_count wraps to 0 after 2^DBITS-1.
- At most one outstanding request at any time.

Decomposition:
- VX_define.vh holds: FE_latch_WIDTH, from_DE_to_FE_WIDTH, from_AGEX_to_FE_WIDTH, STARTPC, CANARY_VALUE, and the state encodings FE_FETCH/FE_WAIT/FE_HOLD.
- One sub-module: fe_hold_buf, a single-entry {valid, inst, pc} register with capture/release/flush inputs.

Test Plan:
- Reset, 1-cycle memory, no stalls:
  - first accepted req addr=0x200; addr 0x204 in the next cycle.
  - Latch after first delivery = {mem[0x200], 0x200, 0x204, 1, 0xC}; back-to-back deliveries, inst_count=1,2,3.
- Stall=1 for 3 cycles after 0x204 is delivered:
  - latch stays at PC 0x204; response for 0x208 goes to HOLD; no request issued.
  - On release: latch PC=0x208, inst_count=3; next cycle req addr=0x20C.
- Redirect to 0x400 while the 0x210 request is outstanding (memory delays 2 cycles):
  - latch=0 and the late response is discarded; next request addr=0x400; inst_count unchanged.
- Redirect together with stall=1 and HOLD valid:
  - latch=0, buffer dropped, next request addr=target.
- imem_req_ready low for 4 cycles:
  - addr stays stable.
  - latch shows bubbles (all zero) while stall=0.
- Assert reset_n=0 mid-WAIT:
  - immediate latch=0, imem_req_valid=0.
  - After release, first request addr=0x200 and the stale response is ignored (bench holds rsp_valid=0 during reset).
